// File: rtl/param_rr_mux_if.sv
// Handshake bundle between N producers, the mux and one consumer.
// The slave modport is the mux side; master is the producer/consumer side.
interface param_rr_mux_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sel;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/param_rr_mux.sv
// N-channel round-robin / fixed-select mux with a registered output stage.
// One cycle handshake-to-output; a stalled full output register drops every in_ready.
module param_rr_mux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  param_rr_mux_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_sel_q;
  logic          out_valid_q;
  logic [SW-1:0] last_grant;

  logic          load_en;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;
  logic [N-1:0]  ready;
  logic          take;

  assign load_en = !out_valid_q || bus.out_ready;
  assign take    = load_en && grant_vld && !rst;

  // Round-robin scans from the farthest candidate back to the nearest so the
  // closest valid channel after last_grant wins without an early exit.
  always_comb begin
    int            c;
    logic [SW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    c         = 0;
    cand      = '0;
    if (bus.mode) begin
      for (int k = 0; k < N; k++) begin
        if (bus.sel == SW'(k) && bus.in_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(k);
        end
      end
    end else begin
      for (int i = N; i >= 1; i--) begin
        c = int'(last_grant) + i;
        if (c >= N) c = c - N;
        cand = SW'(c);
        if (bus.in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // Only the granted lane reaches the register, so garbage on idle lanes cannot leak.
  always_comb begin
    grant_data = '0;
    ready      = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_idx == SW'(k)) begin
        grant_data = bus.in_data[k*W +: W];
        ready[k]   = take;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_grant  <= SW'(N - 1);
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data;
        out_sel_q   <= grant_idx;
        last_grant  <= grant_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: doc/param_rr_mux.md
Name: param_rr_mux

Overview:
- Parametrised successor to the 2:1 CMOS mux: N-channel, W-bit multiplexer with a registered output stage.
- Valid/ready handshake on every input channel and on the output.
- Two selection modes: round-robin arbitration across valid channels, or an explicit select port like the classic mux.
- Sits between multiple producer blocks and one shared consumer.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel in bits.
- SW, $clog2(N), width of the select and channel-index fields (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel k occupies bits [k*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SW  channel index used when mode = 1.
- out_data  output  W  registered selected data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.
- out_sel  output  SW  index of the channel that produced out_data.

Behaviour:
- Single clock (clk). Reset is synchronous, active-high (rst).
- Reset values: out_valid = 0, out_data = 0, out_sel = 0, last_grant = N-1, so the first round-robin search starts at channel 0.
- load_en = !out_valid | out_ready. The output register accepts a new word only when load_en = 1.
- Grant, combinational from current inputs:
  - mode = 0: the first k with in_valid[k] = 1, searching (last_grant+1) mod N upward and wrapping through N-1 to 0.
  - mode = 1: grant = sel if sel < N and in_valid[sel] = 1. Otherwise no grant. sel >= N never grants and never raises in_ready.
- in_ready[g] = load_en & grant_exists, and only for g = grant. All other in_ready bits are 0.
- in_ready never depends on in_valid of other channels in mode 1.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. On the next edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - last_grant <= g
- Latency: one cycle from input handshake to out_valid.
- Throughput: one word per cycle when out_ready is held at 1.
- If load_en = 1 and no grant exists: out_valid <= 0 on the next edge. out_data and out_sel hold their last values.
- If out_valid = 1 and out_ready = 0: out_data, out_sel and out_valid hold, and all in_ready bits are 0 (backpressure).
- Simultaneous output pop and input accept in the same cycle is legal and gives back-to-back words with no bubble.
- last_grant updates on every accepted transfer in both modes, so a switch from mode 1 to mode 0 resumes round-robin after the last served channel.
- Mode or sel changes take effect in the same cycle's grant. They never corrupt a word already held in the output register.
- Round-robin fairness: with all N channels continuously valid and out_ready = 1, the grant sequence is 0,1,...,N-1,0,... Each channel is served exactly once per N transfers.
- Reset mid-operation: the held word is discarded, out_valid = 0 on the cycle after rst is sampled high, and the search pointer returns to channel 0.
- in_data of non-granted channels is ignored. X on those channels must not propagate to the outputs.

Test Plan:
- Reset:
  - Stimulus: drive rst = 1 for 2 cycles with in_valid = 4'b1111.
  - Required: out_valid = 0, in_ready = 0 during reset. After release the first transfer comes from channel 0 and out_sel = 0 one cycle later.
- Round-robin fairness:
  - Stimulus: N = 4, W = 8, mode = 0, in_data = {8'h44, 8'h33, 8'h22, 8'h11}, in_valid = 4'b1111, out_ready = 1 for 8 cycles.
  - Required: out_data sequence 11, 22, 33, 44, 11, 22, 33, 44 and out_sel 0, 1, 2, 3, 0, 1, 2, 3, with no bubbles.
- Sparse valid and wrap-around:
  - Stimulus: mode = 0, in_valid = 4'b1001.
  - Required: grants alternate 0, 3, 0, 3. Channels 1 and 2 never see in_ready = 1.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 3 cycles while out_valid = 1 with out_data = 8'h22.
  - Required: out_data stays 22 and in_ready = 0. When out_ready returns to 1, the next word is 33 in the following cycle.
- Fixed-select mode:
  - Stimulus: mode = 1, sel = 2, in_valid = 4'b1111.
  - Required: every transfer is from channel 2 (out_data = 8'h33, out_sel = 2).
  - Stimulus: set sel = 5 (invalid) with SW = 3 at N = 5... use N = 4 with a forced out-of-range value via a wider-bench check.
  - Required: no grants and out_valid falls to 0.
- Mode switch:
  - Stimulus: after a mode 1 transfer from channel 2, set mode = 0 with in_valid = 4'b1111.
  - Required: the next grant is channel 3, then 0.
